vga_timing_generator_prog: RTL and testbench

Runtime-programmable VGA/video timing generator, the successor to the fixed-parameter sync generator. It produces hsync/vsync, pixel_visible, pixel coordinates and line/frame start strobes. Timing is loaded from a config port into a shadow register and applied only at a frame boundary or while parked, so mode changes never produce a torn frame. It sits between the pixel clock domain's control registers and the framebuffer/scan-out pipeline.

---
 rtl/vga_timing_generator_prog_if.sv | 61 ++++++
 rtl/vga_timing_generator_prog.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_vga_timing_generator_prog.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_generator_prog_if.sv
// Bus bundle for vga_timing_generator_prog.
// Carries the timing configuration port (cfg_*), the config status flags and
// the scan-out timing outputs. The generator is the slave; the control/scan-out
// side is the master. Optional fetch_* look-ahead outputs exist only when
// VGA_TIMING_LOOKAHEAD_EN is defined.
//   cfg_wr, cfg_h*/cfg_v*, cfg_hpol/cfg_vpol : master -> slave
//   cfg_pending, cfg_err                      : slave -> master
//   hsync, vsync, pixel_visible, pixel_x/y,
//   line_start, frame_start (+ fetch_*)       : slave -> master
interface vga_timing_generator_prog_if #(
    parameter int HBITS = 12,
    parameter int VBITS = 11
);
    logic             cfg_wr;
    logic [HBITS-1:0] cfg_hsize;
    logic [HBITS-1:0] cfg_hfp;
    logic [HBITS-1:0] cfg_hsync;
    logic [HBITS-1:0] cfg_hbp;
    logic [VBITS-1:0] cfg_vsize;
    logic [VBITS-1:0] cfg_vfp;
    logic [VBITS-1:0] cfg_vsync;
    logic [VBITS-1:0] cfg_vbp;
    logic             cfg_hpol;
    logic             cfg_vpol;
    logic             cfg_pending;
    logic             cfg_err;
    logic             hsync;
    logic             vsync;
    logic             pixel_visible;
    logic [HBITS-1:0] pixel_x;
    logic [VBITS-1:0] pixel_y;
    logic             line_start;
    logic             frame_start;
`ifdef VGA_TIMING_LOOKAHEAD_EN
    logic [HBITS-1:0] fetch_x;
    logic [VBITS-1:0] fetch_y;
    logic             fetch_valid;
`endif

    modport master (
`ifdef VGA_TIMING_LOOKAHEAD_EN
        input  fetch_x, fetch_y, fetch_valid,
`endif
        output cfg_wr, cfg_hsize, cfg_hfp, cfg_hsync, cfg_hbp,
        output cfg_vsize, cfg_vfp, cfg_vsync, cfg_vbp, cfg_hpol, cfg_vpol,
        input  cfg_pending, cfg_err,
        input  hsync, vsync, pixel_visible, pixel_x, pixel_y,
        input  line_start, frame_start
    );

    modport slave (
`ifdef VGA_TIMING_LOOKAHEAD_EN
        output fetch_x, fetch_y, fetch_valid,
`endif
        input  cfg_wr, cfg_hsize, cfg_hfp, cfg_hsync, cfg_hbp,
        input  cfg_vsize, cfg_vfp, cfg_vsync, cfg_vbp, cfg_hpol, cfg_vpol,
        output cfg_pending, cfg_err,
        output hsync, vsync, pixel_visible, pixel_x, pixel_y,
        output line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_generator_prog.sv
// Runtime-programmable VGA timing generator.
// Timing written through the cfg port lands in a shadow register and is moved
// to the active register only when leaving the last position of a frame
// (frame wrap, or the first enabled edge after parking), so a frame is never
// generated with mixed timing.
// Ports:
//   pixel_clk : pixel clock
//   reset_n   : asynchronous active-low reset (loads DEF_* timing, parks)
//   enable    : 1 = run, 0 = park at (HTOTAL-1, VTOTAL-1) with idle outputs
//   bus       : vga_timing_generator_prog_if.slave (config + timing outputs)
// Optional build macro VGA_TIMING_LOOKAHEAD_EN: adds fetch_x/fetch_y/
// fetch_valid carrying the undelayed position, and delays all display
// outputs by LOOKAHEAD cycles.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_PARKED  | counters held at last frame position, outputs idle
// ST_RUN     | counters advancing, outputs follow timing
module vga_timing_generator_prog #(
    parameter int HBITS     = 12,
    parameter int VBITS     = 11,
    parameter int DEF_HSIZE = 640,
    parameter int DEF_HFP   = 16,
    parameter int DEF_HSYNC = 96,
    parameter int DEF_HBP   = 48,
    parameter int DEF_VSIZE = 480,
    parameter int DEF_VFP   = 10,
    parameter int DEF_VSYNC = 2,
    parameter int DEF_VBP   = 33,
    parameter bit DEF_HPOL  = 1'b0,
    parameter bit DEF_VPOL  = 1'b0,
    parameter int LOOKAHEAD = 2
) (
    input  logic pixel_clk,
    input  logic reset_n,
    input  logic enable,
    vga_timing_generator_prog_if.slave bus
);

    localparam int HW = HBITS + 2;
    localparam int VW = VBITS + 2;

    if (LOOKAHEAD < 1 || LOOKAHEAD > 8) begin : g_bad_lookahead
        $error("LOOKAHEAD must be in 1..8");
    end

    typedef struct packed {
        logic [HBITS-1:0] hsize;
        logic [HBITS-1:0] hfp;
        logic [HBITS-1:0] hsync;
        logic [HBITS-1:0] hbp;
        logic [VBITS-1:0] vsize;
        logic [VBITS-1:0] vfp;
        logic [VBITS-1:0] vsync;
        logic [VBITS-1:0] vbp;
        logic             hpol;
        logic             vpol;
    } timing_t;

    typedef struct packed {
        logic             hs;
        logic             vs;
        logic             vis;
        logic [HBITS-1:0] x;
        logic [VBITS-1:0] y;
        logic             ls;
        logic             fs;
    } vid_t;

    typedef enum logic {ST_PARKED, ST_RUN} state_t;

    localparam timing_t DEF_TIMING = '{
        hsize: HBITS'(DEF_HSIZE), hfp: HBITS'(DEF_HFP),
        hsync: HBITS'(DEF_HSYNC), hbp: HBITS'(DEF_HBP),
        vsize: VBITS'(DEF_VSIZE), vfp: VBITS'(DEF_VFP),
        vsync: VBITS'(DEF_VSYNC), vbp: VBITS'(DEF_VBP),
        hpol: DEF_HPOL, vpol: DEF_VPOL};

    localparam logic [HBITS-1:0] DEF_PARK_COL =
        HBITS'(DEF_HSIZE + DEF_HFP + DEF_HSYNC + DEF_HBP - 1);
    localparam logic [VBITS-1:0] DEF_PARK_ROW =
        VBITS'(DEF_VSIZE + DEF_VFP + DEF_VSYNC + DEF_VBP - 1);

    localparam vid_t VID_IDLE = '{
        hs: ~DEF_HPOL, vs: ~DEF_VPOL, vis: 1'b0,
        x: '0, y: '0, ls: 1'b0, fs: 1'b0};

    function automatic logic [HW-1:0] htotal(input timing_t t);
        return HW'(t.hsize) + HW'(t.hfp) + HW'(t.hsync) + HW'(t.hbp);
    endfunction

    function automatic logic [VW-1:0] vtotal(input timing_t t);
        return VW'(t.vsize) + VW'(t.vfp) + VW'(t.vsync) + VW'(t.vbp);
    endfunction

    state_t           state_q, state_d;
    timing_t          active_q, active_d;
    timing_t          shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic [HBITS-1:0] col_q, col_d;
    logic [VBITS-1:0] row_q, row_d;
    vid_t             vid_q, vid_d;
    logic             pend_o_q, pend_o_d;
    logic             err_q, err_d;

    timing_t          wr_t;
    logic             wr_ok;
    logic [HW-1:0]    htot_q;
    logic [VW-1:0]    vtot_q;
    logic             col_last;
    logic             row_last;

    assign htot_q   = htotal(active_q);
    assign vtot_q   = vtotal(active_q);
    assign col_last = (HW'(col_q) == htot_q - HW'(1));
    assign row_last = (VW'(row_q) == vtot_q - VW'(1));

    // Write validation: nonzero active size and sync width, porches free,
    // totals must fit the counters.
    always_comb begin
        wr_t = '{
            hsize: bus.cfg_hsize, hfp: bus.cfg_hfp,
            hsync: bus.cfg_hsync, hbp: bus.cfg_hbp,
            vsize: bus.cfg_vsize, vfp: bus.cfg_vfp,
            vsync: bus.cfg_vsync, vbp: bus.cfg_vbp,
            hpol: bus.cfg_hpol, vpol: bus.cfg_vpol};
        wr_ok = (wr_t.hsize != '0) && (wr_t.vsize != '0) &&
                (wr_t.hsync != '0) && (wr_t.vsync != '0) &&
                (htotal(wr_t) <= (HW'(1) << HBITS)) &&
                (vtotal(wr_t) <= (VW'(1) << VBITS));
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_PARKED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, next position and config bookkeeping.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        col_d    = col_q;
        row_d    = row_q;
        err_d    = 1'b0;

        case (state_q)
            ST_PARKED: begin
                if (enable) begin
                    state_d = ST_RUN;
                    col_d   = '0;
                    row_d   = '0;
                    if (pend_q) begin
                        active_d = shadow_q;
                        pend_d   = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_PARKED;
                    col_d   = HBITS'(htot_q - HW'(1));
                    row_d   = VBITS'(vtot_q - VW'(1));
                end else if (col_last) begin
                    col_d = '0;
                    if (row_last) begin
                        row_d = '0;
                        if (pend_q) begin
                            active_d = shadow_q;
                            pend_d   = 1'b0;
                        end
                    end else begin
                        row_d = row_q + VBITS'(1);
                    end
                end else begin
                    col_d = col_q + HBITS'(1);
                end
            end
            default: begin
                state_d = ST_PARKED;
            end
        endcase

        // Applied after the apply step so a write on the apply edge stays
        // pending for the next boundary.
        if (bus.cfg_wr) begin
            if (wr_ok) begin
                shadow_d = wr_t;
                pend_d   = 1'b1;
            end else begin
                err_d = enable;
            end
        end
    end

    // Outputs are computed from the next position and next active config so
    // the registered values describe the current position with no lag.
    always_comb begin
        logic          run_d;
        logic [HW-1:0] hs_lo;
        logic [HW-1:0] hs_hi;
        logic [VW-1:0] vs_lo;
        logic [VW-1:0] vs_hi;

        run_d = (state_d == ST_RUN);
        hs_lo = HW'(active_d.hsize) + HW'(active_d.hfp);
        hs_hi = hs_lo + HW'(active_d.hsync);
        vs_lo = VW'(active_d.vsize) + VW'(active_d.vfp);
        vs_hi = vs_lo + VW'(active_d.vsync);

        vid_d     = VID_IDLE;
        vid_d.hs  = ~active_d.hpol;
        vid_d.vs  = ~active_d.vpol;
        if (run_d) begin
            vid_d.vis = (col_d < active_d.hsize) && (row_d < active_d.vsize);
            if (HW'(col_d) >= hs_lo && HW'(col_d) < hs_hi) begin
                vid_d.hs = active_d.hpol;
            end
            if (VW'(row_d) >= vs_lo && VW'(row_d) < vs_hi) begin
                vid_d.vs = active_d.vpol;
            end
            vid_d.x  = vid_d.vis ? col_d : '0;
            vid_d.y  = vid_d.vis ? row_d : '0;
            vid_d.ls = (col_d == '0);
            vid_d.fs = (col_d == '0) && (row_d == '0);
        end
        pend_o_d = run_d && pend_d;
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= DEF_TIMING;
            shadow_q <= DEF_TIMING;
            pend_q   <= 1'b0;
            col_q    <= DEF_PARK_COL;
            row_q    <= DEF_PARK_ROW;
            vid_q    <= VID_IDLE;
            pend_o_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            col_q    <= col_d;
            row_q    <= row_d;
            vid_q    <= vid_d;
            pend_o_q <= pend_o_d;
            err_q    <= err_d;
        end
    end

    vid_t vid_disp;

`ifdef VGA_TIMING_LOOKAHEAD_EN
    // Display outputs trail the fetch coordinates so framebuffer read latency
    // is hidden.
    vid_t dly_q [LOOKAHEAD];

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LOOKAHEAD; i++) begin
                dly_q[i] <= VID_IDLE;
            end
        end else begin
            dly_q[0] <= vid_q;
            for (int i = 1; i < LOOKAHEAD; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign vid_disp        = dly_q[LOOKAHEAD-1];
    assign bus.fetch_x     = vid_q.x;
    assign bus.fetch_y     = vid_q.y;
    assign bus.fetch_valid = vid_q.vis;
`else
    assign vid_disp = vid_q;
`endif

    assign bus.hsync         = vid_disp.hs;
    assign bus.vsync         = vid_disp.vs;
    assign bus.pixel_visible = vid_disp.vis;
    assign bus.pixel_x       = vid_disp.x;
    assign bus.pixel_y       = vid_disp.y;
    assign bus.line_start    = vid_disp.ls;
    assign bus.frame_start   = vid_disp.fs;
    assign bus.cfg_pending   = pend_o_q;
    assign bus.cfg_err       = err_q;

endmodule

// File: tb/tb_vga_timing_generator_prog.sv
module tb_vga_timing_generator_prog;
    localparam int HBITS = 12;
    localparam int VBITS = 11;
`ifdef VGA_TIMING_LOOKAHEAD_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif

    logic pixel_clk = 1'b0;
    logic reset_n   = 1'b0;
    logic enable    = 1'b0;

    always #5 pixel_clk = ~pixel_clk;

    vga_timing_generator_prog_if #(.HBITS(HBITS), .VBITS(VBITS)) bus ();

    vga_timing_generator_prog #(
        .HBITS(HBITS), .VBITS(VBITS), .LOOKAHEAD(2)
    ) dut (
        .pixel_clk(pixel_clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .bus      (bus)
    );

    typedef struct {
        int hsize, hfp, hsync, hbp;
        int vsize, vfp, vsync, vbp;
        bit hpol, vpol;
    } cfg_t;

    typedef struct packed {
        logic        vis;
        logic [11:0] x;
        logic [10:0] y;
        logic        hs, vs, ls, fs;
    } exp_t;

    int n_checks = 0;
    int n_errors = 0;

    cfg_t def_cfg = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg_t m_act, m_sh;
    bit   m_pend, m_run, m_err;
    int   m_idx;
    exp_t hist[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int htot(input cfg_t c);
        return c.hsize + c.hfp + c.hsync + c.hbp;
    endfunction

    function automatic int vtot(input cfg_t c);
        return c.vsize + c.vfp + c.vsync + c.vbp;
    endfunction

    function automatic bit cfg_ok(input cfg_t c);
        return c.hsize >= 1 && c.vsize >= 1 && c.hsync >= 1 && c.vsync >= 1 &&
               htot(c) <= (1 << HBITS) && vtot(c) <= (1 << VBITS);
    endfunction

    function automatic exp_t idle_of(input cfg_t c);
        exp_t e;
        e = '0;
        e.hs = !c.hpol;
        e.vs = !c.vpol;
        return e;
    endfunction

    // Position is tracked as a linear index within the frame.
    function automatic exp_t expect_now();
        exp_t e;
        int col, row;
        e = idle_of(m_act);
        if (m_run) begin
            col   = m_idx % htot(m_act);
            row   = m_idx / htot(m_act);
            e.vis = (col < m_act.hsize) && (row < m_act.vsize);
            e.x   = e.vis ? 12'(col) : 12'd0;
            e.y   = e.vis ? 11'(row) : 11'd0;
            if (col >= m_act.hsize + m_act.hfp && col < m_act.hsize + m_act.hfp + m_act.hsync)
                e.hs = m_act.hpol;
            if (row >= m_act.vsize + m_act.vfp && row < m_act.vsize + m_act.vfp + m_act.vsync)
                e.vs = m_act.vpol;
            e.ls = (col == 0);
            e.fs = (m_idx == 0);
        end
        return e;
    endfunction

    task automatic model_reset();
        m_act  = def_cfg;
        m_sh   = def_cfg;
        m_pend = 0;
        m_run  = 0;
        m_err  = 0;
        m_idx  = htot(def_cfg) * vtot(def_cfg) - 1;
        hist.delete();
        for (int i = 0; i <= DLY; i++) hist.push_front(idle_of(def_cfg));
    endtask

    function automatic cfg_t bus_cfg();
        cfg_t c;
        c = '{int'(bus.cfg_hsize), int'(bus.cfg_hfp), int'(bus.cfg_hsync), int'(bus.cfg_hbp),
              int'(bus.cfg_vsize), int'(bus.cfg_vfp), int'(bus.cfg_vsync), int'(bus.cfg_vbp),
              bus.cfg_hpol, bus.cfg_vpol};
        return c;
    endfunction

    task automatic model_step();
        cfg_t c;
        int   total;
        c     = bus_cfg();
        total = htot(m_act) * vtot(m_act);
        if (!enable) begin
            m_run = 0;
            m_idx = total - 1;
        end else begin
            if (m_idx == total - 1) begin
                if (m_pend) begin
                    m_act  = m_sh;
                    m_pend = 0;
                end
                m_idx = 0;
            end else begin
                m_idx++;
            end
            m_run = 1;
        end
        m_err = 0;
        if (bus.cfg_wr) begin
            if (cfg_ok(c)) begin
                m_sh   = c;
                m_pend = 1;
            end else begin
                m_err = enable;
            end
        end
        hist.push_front(expect_now());
        while (hist.size() > DLY + 1) void'(hist.pop_back());
    endtask

    task automatic check_all();
        exp_t e;
        e = hist[DLY];
        chk("pixel_visible", bus.pixel_visible, e.vis);
        chk("pixel_x", bus.pixel_x, e.x);
        chk("pixel_y", bus.pixel_y, e.y);
        chk("hsync", bus.hsync, e.hs);
        chk("vsync", bus.vsync, e.vs);
        chk("line_start", bus.line_start, e.ls);
        chk("frame_start", bus.frame_start, e.fs);
        chk("cfg_pending", bus.cfg_pending, m_run && m_pend);
        chk("cfg_err", bus.cfg_err, m_err);
`ifdef VGA_TIMING_LOOKAHEAD_EN
        chk("fetch_valid", bus.fetch_valid, hist[0].vis);
        chk("fetch_x", bus.fetch_x, hist[0].x);
        chk("fetch_y", bus.fetch_y, hist[0].y);
`endif
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_cfg(input cfg_t c);
        bus.cfg_hsize = 12'(c.hsize);
        bus.cfg_hfp   = 12'(c.hfp);
        bus.cfg_hsync = 12'(c.hsync);
        bus.cfg_hbp   = 12'(c.hbp);
        bus.cfg_vsize = 11'(c.vsize);
        bus.cfg_vfp   = 11'(c.vfp);
        bus.cfg_vsync = 11'(c.vsync);
        bus.cfg_vbp   = 11'(c.vbp);
        bus.cfg_hpol  = c.hpol;
        bus.cfg_vpol  = c.vpol;
    endtask

    task automatic write_cfg(input cfg_t c);
        drive_cfg(c);
        bus.cfg_wr = 1'b1;
        tick();
        bus.cfg_wr = 1'b0;
    endtask

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c = '{int'($urandom_range(1, 8)), int'($urandom_range(0, 3)),
              int'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(1, 5)), int'($urandom_range(0, 2)),
              int'($urandom_range(1, 2)), int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
        if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 5))
                0: c.hsize = 0;
                1: c.hsync = 0;
                2: c.vsize = 0;
                3: c.vsync = 0;
                4: begin c.hsize = 4000; c.hfp = 97; end
                default: begin c.vsize = 2040; c.vfp = 5; c.vsync = 2; c.vbp = 2; end
            endcase
        end
        return c;
    endfunction

    cfg_t cfg_a  = '{8, 2, 3, 1, 4, 1, 2, 1, 1'b0, 1'b0};
    cfg_t cfg_a2 = '{5, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1};
    cfg_t cfg_b  = '{6, 0, 1, 2, 2, 0, 1, 1, 1'b0, 1'b1};
    cfg_t cfg_big = '{4000, 90, 4, 2, 1, 0, 1, 0, 1'b1, 1'b0};
    cfg_t cfg_bad;

    initial begin
        bus.cfg_wr = 1'b0;
        drive_cfg(def_cfg);
        model_reset();
        #12;
        check_all();
        reset_n = 1'b1;
        enable  = 1'b1;

        // Default mode: first two lines and a bit.
        run(1700);

        // Small mode written mid-frame, then rejected writes.
        write_cfg(cfg_a);
        run(20);
        cfg_bad = cfg_a;
        cfg_bad.hsync = 0;
        write_cfg(cfg_bad);
        cfg_bad = cfg_a;
        cfg_bad.hsize = 4000;
        cfg_bad.hfp   = 97;
        write_cfg(cfg_bad);
        chk("pending_after_bad", bus.cfg_pending, 1);
        run(5);

        // Park, then re-enable applies the pending small mode.
        enable = 1'b0;
        run(5);
        enable = 1'b1;
        run(300);

        // Write on the frame-wrap edge while another config is pending.
        write_cfg(cfg_a2);
        begin
            int guard;
            guard = 0;
            while (!(m_run && m_idx == htot(m_act) * vtot(m_act) - 2) && guard < 500) begin
                tick();
                guard++;
            end
            chk("wrap_wait_timeout", guard < 500, 1);
        end
        tick();
        write_cfg(cfg_b);
        chk("pending_after_wrap_write", bus.cfg_pending, 1);
        run(200);

        // Largest legal line length.
        write_cfg(cfg_big);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        run(8300);

        // Asynchronous reset mid-line.
        write_cfg(cfg_a);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        run(23);
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all();
        #3 reset_n = 1'b1;
        run(50);

        // Randomized traffic.
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                drive_cfg(rand_cfg());
                bus.cfg_wr = 1'b1;
            end else begin
                bus.cfg_wr = 1'b0;
            end
            enable = ($urandom_range(0, 149) != 0);
            tick();
        end
        bus.cfg_wr = 1'b0;
        enable = 1'b1;
        run(20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
